// File: rtl/fu_issue_pkg.sv
// Shared types and constants for the functional-unit instruction issuer.
package fu_issue_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } issue_state_e;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_ADDN = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_MAX  = 3'd4;
    localparam logic [2:0] OP_MIN  = 3'd5;
    localparam logic [2:0] OP_SHR  = 3'd6;
    localparam logic [2:0] OP_SHL  = 3'd7;

    localparam logic [2:0] SEL_CA = 3'b000;
    localparam logic [2:0] SEL_BC = 3'b011;
    localparam logic [2:0] SEL_AC = 3'b101;
    localparam logic [2:0] SEL_AB = 3'b110;

endpackage

// File: rtl/fu_instr_issuer_if.sv
// Host/issuer signal bundle. The loop input exists only when ISSUE_LOOP_EN is defined.
interface fu_instr_issuer_if #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned OP_W  = 3,
    parameter int unsigned SEL_W = 3
);
    localparam int unsigned INS_W = 1 << OP_W;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             wr_en;
    logic [OP_W-1:0]  wr_op;
    logic [SEL_W-1:0] wr_sel;
    logic             clear;
    logic             start;
    logic             abort;
    logic             out_ready;
`ifdef ISSUE_LOOP_EN
    logic             loop;
`endif
    logic [INS_W-1:0] instruction;
    logic [SEL_W-1:0] select;
    logic             out_valid;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             wr_err;

    // Host side
    modport master (
`ifdef ISSUE_LOOP_EN
        output loop,
`endif
        output wr_en, wr_op, wr_sel, clear, start, abort, out_ready,
        input  instruction, select, out_valid, busy, done, count, full, wr_err
    );

    // Issuer side
    modport slave (
`ifdef ISSUE_LOOP_EN
        input  loop,
`endif
        input  wr_en, wr_op, wr_sel, clear, start, abort, out_ready,
        output instruction, select, out_valid, busy, done, count, full, wr_err
    );

endinterface

// File: rtl/fu_op_decoder.sv
// Binary opcode to one-hot instruction decoder (inverse of the FU priority encoder).
module fu_op_decoder #(
    parameter int unsigned OP_W = 3
) (
    input  logic [OP_W-1:0]        op,
    output logic [(1 << OP_W)-1:0] onehot
);

    always_comb begin
        onehot     = '0;
        onehot[op] = 1'b1;
    end

endmodule

// File: rtl/fu_instr_issuer.sv
// Program buffer + replay sequencer feeding the FU instruction/select inputs.
// Optional ISSUE_LOOP_EN adds continuous replay controlled by bus.loop.
module fu_instr_issuer
    import fu_issue_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned OP_W  = 3,
    parameter int unsigned SEL_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    fu_instr_issuer_if.slave  bus
);

    localparam int unsigned INS_W = 1 << OP_W;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    issue_state_e     state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] run_len_q, run_len_d;

    logic [INS_W-1:0] instr_q, instr_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic             wr_err_q, wr_err_d;
    logic             busy_q, full_q;

    logic [OP_W-1:0]  op_mem  [DEPTH];
    logic [SEL_W-1:0] sel_mem [DEPTH];
    logic             mem_we;

    logic             is_last;
    logic             bypass;
    logic [PTR_W-1:0] rd_idx;
    logic [OP_W-1:0]  rd_op;
    logic [SEL_W-1:0] rd_sel;
    logic [INS_W-1:0] rd_onehot;

    assign is_last = (CNT_W'(rd_ptr_q) + CNT_W'(1)) == run_len_q;

    // Entry to present next: the successor in RUN (wrapping on the last), else entry 0
    always_comb begin
        rd_idx = '0;
        if (state_q == ST_RUN && !is_last) begin
            rd_idx = rd_ptr_q + PTR_W'(1);
        end
    end

    // A write landing in an empty buffer on the start cycle is not in memory yet
    assign bypass = (state_q == ST_IDLE) && (count_q == '0);
    assign rd_op  = bypass ? bus.wr_op  : op_mem[rd_idx];
    assign rd_sel = bypass ? bus.wr_sel : sel_mem[rd_idx];

    fu_op_decoder #(.OP_W(OP_W)) u_dec (
        .op     (rd_op),
        .onehot (rd_onehot)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        run_len_d = run_len_q;
        instr_d   = instr_q;
        sel_d     = sel_q;
        valid_d   = valid_q;
        done_d    = 1'b0;
        wr_err_d  = 1'b0;
        mem_we    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.clear) begin
                    count_d  = '0;
                    wr_ptr_d = '0;
                end else if (bus.wr_en) begin
                    if (count_q == CNT_W'(DEPTH)) begin
                        wr_err_d = 1'b1;
                    end else begin
                        mem_we   = 1'b1;
                        count_d  = count_q + CNT_W'(1);
                        wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    end
                end
                if (bus.start && count_d != '0) begin
                    state_d   = ST_RUN;
                    run_len_d = count_d;
                    rd_ptr_d  = '0;
                    valid_d   = 1'b1;
                    instr_d   = rd_onehot;
                    sel_d     = rd_sel;
                end
            end
            ST_RUN: begin
                wr_err_d = bus.wr_en;
                if (bus.abort) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    instr_d = '0;
                end else if (bus.out_ready) begin
                    if (is_last) begin
`ifdef ISSUE_LOOP_EN
                        if (bus.loop) begin
                            rd_ptr_d = '0;
                            instr_d  = rd_onehot;
                            sel_d    = rd_sel;
                        end else
`endif
                        begin
                            state_d = ST_DONE;
                            valid_d = 1'b0;
                            instr_d = '0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        rd_ptr_d = rd_ptr_q + PTR_W'(1);
                        instr_d  = rd_onehot;
                        sel_d    = rd_sel;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            run_len_q <= '0;
            instr_q   <= '0;
            sel_q     <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            wr_err_q  <= 1'b0;
            busy_q    <= 1'b0;
            full_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            run_len_q <= run_len_d;
            instr_q   <= instr_d;
            sel_q     <= sel_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            wr_err_q  <= wr_err_d;
            busy_q    <= (state_d != ST_IDLE);
            full_q    <= (count_d == CNT_W'(DEPTH));
        end
    end

    // Program storage has no reset; contents are only read below count
    always_ff @(posedge clk) begin
        if (mem_we) begin
            op_mem[wr_ptr_q]  <= bus.wr_op;
            sel_mem[wr_ptr_q] <= bus.wr_sel;
        end
    end

    assign bus.instruction = instr_q;
    assign bus.select      = sel_q;
    assign bus.out_valid   = valid_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.count       = count_q;
    assign bus.full        = full_q;
    assign bus.wr_err      = wr_err_q;

endmodule
